// File: rtl/cram_fifo_ctrl.sv
// Streaming FIFO controller around a two-half-bank CRAM: packs beats into rows, reads rows into a skid buffer.
// Optional synchronous flush port enabled by defining CRAM_FIFO_FLUSH_EN.
module cram_fifo_ctrl #(
  parameter int CRAM_DEPTH = 16,
  parameter int CRAM_WIDTH = 128,
  parameter int OBUF_DEPTH = 3
) (
  input  logic                          clk,
  input  logic                          rst,
`ifdef CRAM_FIFO_FLUSH_EN
  input  logic                          flush,
`endif
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CRAM_WIDTH/2-1:0]       in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CRAM_WIDTH-1:0]         out_data,
  output logic                          cram_CE_a,
  output logic                          cram_CE_b,
  output logic                          cram_WE_a,
  output logic                          cram_WE_b,
  output logic [CRAM_WIDTH-1:0]         cram_D,
  output logic [$clog2(CRAM_DEPTH)-1:0] cram_wr_addr,
  output logic [$clog2(CRAM_DEPTH)-1:0] cram_rd_addr,
  input  logic [CRAM_WIDTH-1:0]         cram_Q,
  output logic [$clog2(CRAM_DEPTH):0]   count,
  output logic                          empty,
  output logic                          full
);
  localparam int AW = $clog2(CRAM_DEPTH);
  localparam int OW = $clog2(OBUF_DEPTH);
  localparam int CW = $clog2(OBUF_DEPTH + 1);

  typedef enum logic {LO = 1'b0, HI = 1'b1} half_e;

  logic                  flush_i;
  half_e                 half_q, half_d;
  logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]            vld_pipe_q, vld_pipe_d;
  logic [CRAM_WIDTH-1:0] obuf_q [OBUF_DEPTH];
  logic [CRAM_WIDTH-1:0] obuf_d [OBUF_DEPTH];
  logic [OW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         ocnt_q, ocnt_d;
  logic [CW:0]           occ;
  logic                  rd_issue, acc, wr_lo, wr_hi, push, pop;

`ifdef CRAM_FIFO_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(CRAM_DEPTH));

  // Reads see only registered occupancy, so out_ready never reaches the CRAM enables.
  assign occ      = (CW+1)'(vld_pipe_q[0]) + (CW+1)'(vld_pipe_q[1]) + (CW+1)'(ocnt_q);
  assign rd_issue = !empty && (occ < (CW+1)'(OBUF_DEPTH)) && !flush_i;
  assign in_ready = !full && !rd_issue && !flush_i;
  assign acc      = in_valid && in_ready;

  // Pack FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) half_q <= LO;
    else     half_q <= half_d;
  end

  // Pack FSM: next state
  always_comb begin
    half_d = half_q;
    if (flush_i)  half_d = LO;
    else if (acc) half_d = (half_q == LO) ? HI : LO;
  end

  // Pack FSM: outputs (read issue shares the enables; the two never coincide)
  always_comb begin
    wr_lo        = acc && (half_q == LO);
    wr_hi        = acc && (half_q == HI);
    cram_CE_a    = rd_issue || wr_lo;
    cram_CE_b    = rd_issue || wr_hi;
    cram_WE_a    = wr_lo;
    cram_WE_b    = wr_hi;
    cram_D       = {in_data, in_data};
    cram_wr_addr = wr_ptr_q[AW-1:0];
    cram_rd_addr = rd_ptr_q[AW-1:0];
  end

  assign push      = vld_pipe_q[1];
  assign out_valid = (ocnt_q != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? obuf_q[head_q] : '0;

  always_comb begin
    wr_ptr_d   = wr_ptr_q + (AW+1)'(wr_hi);
    rd_ptr_d   = rd_ptr_q + (AW+1)'(rd_issue);
    vld_pipe_d = {vld_pipe_q[0], rd_issue};
    obuf_d     = obuf_q;
    head_d     = head_q;
    tail_d     = tail_q;
    ocnt_d     = ocnt_q + CW'(push) - CW'(pop);
    if (push) begin
      obuf_d[tail_q] = cram_Q;
      tail_d = (tail_q == OW'(OBUF_DEPTH-1)) ? '0 : tail_q + 1'b1;
    end
    if (pop) head_d = (head_q == OW'(OBUF_DEPTH-1)) ? '0 : head_q + 1'b1;
    // Flush kills reads still in the CRAM pipe so their data never lands.
    if (flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      vld_pipe_d = '0;
      head_d     = '0;
      tail_d     = '0;
      ocnt_d     = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      vld_pipe_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      ocnt_q     <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++) obuf_q[i] <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      vld_pipe_q <= vld_pipe_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      ocnt_q     <= ocnt_d;
      obuf_q     <= obuf_d;
    end
  end
endmodule
